ifetch_buffer: RTL and testbench

//   Instruction fetch stage. It sits between the PC register and decode.
//   - Owns the sequential fetch pointer and issues word requests to instruction memory over a req/ack handshake.
//   - Buffers returned words with their PCs in a small FIFO.
//   - Presents them to decode over a valid/ready interface.
//   - Branch/jump redirects flush the queue and restart fetch at the new address.

---
 rtl/ifetch_buffer.sv | 127 ++++++++++++
 tb/tb_ifetch_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction fetch stage: the fetch pointer drives an imem req/ack port, and returned words queue in a DEPTH-entry FIFO for decode.
// Latency: an ack in cycle N makes the word visible on inst_* in N+1. Backpressure: requests stop when the FIFO is full.
// Optional macro IFETCH_STALL_CNT_EN enables the saturating stall_cycles bubble counter; otherwise it reads 0.
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00400020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc,
  output logic [31:0] stall_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FETCH, FULL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     stale_q, stale_d;
  logic [CW-1:0]   count_q, count_nx;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]     mem_data [DEPTH];
  logic [31:0]     mem_pc   [DEPTH];
  logic            ack, push, pop;

  assign imem_req   = !reset && (state_q != FULL);
  assign imem_addr  = (state_q == DRAIN) ? stale_q : fetch_pc_q;
  assign fetch_pc   = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = mem_data[rd_ptr_q];
  assign inst_pc    = mem_pc[rd_ptr_q];

  // A flush voids both the same-cycle push and pop.
  assign ack      = imem_ack && imem_req;
  assign push     = (state_q == FETCH) && ack && !redirect;
  assign pop      = inst_valid && inst_ready && !redirect;
  assign count_nx = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    if (redirect) begin
      fetch_pc_d = redirect_addr & 32'hFFFF_FFFC;
      case (state_q)
        FETCH: begin
          if (!ack) begin
            state_d = DRAIN;
            stale_d = fetch_pc_q;
          end
        end
        FULL:    state_d = FETCH;
        DRAIN:   if (ack) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (push) fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_nx == CW'(DEPTH)) state_d = FULL;
        end
        FULL:    if (pop) state_d = FETCH;
        DRAIN:   if (ack) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      stale_q    <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
      if (redirect) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q <= count_nx;
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]   <= fetch_pc_q;
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (inst_ready && !inst_valid && !redirect && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed self-checking bench for ifetch_buffer: streaming, full backpressure, redirect/drain, wrap, mid-drain reset, stall counter.
module tb_ifetch_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;
  logic [31:0] stall_cycles;

  integer n_cmp = 0;
  integer n_err = 0;

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h00400020)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_pc(fetch_pc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; redirect = 1'b0; redirect_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; redirect = 1'b0; redirect_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (fetch_pc !== 32'h00400020) begin n_err++; $display("FAIL reset_pc got=%h exp=00400020", fetch_pc); end
    n_cmp++; if (stall_cycles !== 32'h0) begin n_err++; $display("FAIL reset_stall got=%h exp=0", stall_cycles); end
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400020) begin
      n_err++; $display("FAIL first_req got=%b/%h exp=1/00400020", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    do_reset();
    inst_ready = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (imem_addr !== 32'h00400020 + 32'(4 * i)) begin
        n_err++; $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, 32'h00400020 + 32'(4 * i));
      end
      imem_rdata = 32'hC0DE0000 + 32'(i);
      tick();
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h00400020 + 32'(4 * i)) begin
        n_err++; $display("FAIL stream_pc%0d got=%b/%h exp=1/%h", i, inst_valid, inst_pc, 32'h00400020 + 32'(4 * i));
      end
      n_cmp++; if (inst_data !== 32'hC0DE0000 + 32'(i)) begin
        n_err++; $display("FAIL stream_data%0d got=%h exp=%h", i, inst_data, 32'hC0DE0000 + 32'(i));
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_full;
    do_reset();
    inst_ready = 1'b0; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_rdata = 32'h100 + 32'(i);
      tick();
    end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL full_req got=%b exp=0", imem_req); end
    n_cmp++; if (fetch_pc !== 32'h00400030) begin n_err++; $display("FAIL full_pc got=%h exp=00400030", fetch_pc); end
    n_cmp++; if (inst_pc !== 32'h00400020 || inst_data !== 32'h100) begin
      n_err++; $display("FAIL full_head got=%h/%h exp=00400020/00000100", inst_pc, inst_data);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400030) begin
      n_err++; $display("FAIL full_resume got=%b/%h exp=1/00400030", imem_req, imem_addr);
    end
    n_cmp++; if (inst_pc !== 32'h00400024) begin n_err++; $display("FAIL full_pop got=%h exp=00400024", inst_pc); end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_drain;
    do_reset();
    inst_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_addr = 32'h00400103;
    tick();
    redirect = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400020) begin
      n_err++; $display("FAIL drain_hold got=%b/%h exp=1/00400020", imem_req, imem_addr);
    end
    n_cmp++; if (fetch_pc !== 32'h00400100) begin n_err++; $display("FAIL drain_pc got=%h exp=00400100", fetch_pc); end
    tick(); tick();
    n_cmp++; if (imem_addr !== 32'h00400020 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_wait got=%h/%b exp=00400020/0", imem_addr, inst_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEADDEAD;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (imem_addr !== 32'h00400100 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_done got=%h/%b exp=00400100/0", imem_addr, inst_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'hBEEF0001;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h00400100 || inst_data !== 32'hBEEF0001) begin
      n_err++; $display("FAIL drain_word got=%b/%h/%h exp=1/00400100/beef0001", inst_valid, inst_pc, inst_data);
    end
  endtask

  task automatic test_redirect_ack_pop;
    do_reset();
    inst_ready = 1'b0; imem_ack = 1'b1;
    tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || fetch_pc !== 32'h00400028) begin
      n_err++; $display("FAIL rap_setup got=%b/%h exp=1/00400028", inst_valid, fetch_pc);
    end
    inst_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h00400200;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || fetch_pc !== 32'h00400200 || imem_addr !== 32'h00400200) begin
      n_err++; $display("FAIL rap_flush got=%b/%h/%h exp=0/00400200/00400200", inst_valid, fetch_pc, imem_addr);
    end
  endtask

  task automatic test_wrap_and_reset;
    inst_ready = 1'b1; imem_ack = 1'b1;
    redirect = 1'b1; redirect_addr = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFFFFFC || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_start got=%h/%b exp=fffffffc/0", imem_addr, inst_valid);
    end
    imem_rdata = 32'h11111111;
    tick();
    n_cmp++; if (inst_pc !== 32'hFFFFFFFC || fetch_pc !== 32'h0) begin
      n_err++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/00000000", inst_pc, fetch_pc);
    end
    imem_rdata = 32'h22222222;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (inst_pc !== 32'h0 || inst_data !== 32'h22222222) begin
      n_err++; $display("FAIL wrap_zero got=%h/%h exp=00000000/22222222", inst_pc, inst_data);
    end
    redirect = 1'b1; redirect_addr = 32'h00400300;
    tick();
    redirect = 1'b0;
    n_cmp++; if (imem_addr !== 32'h00000004 || fetch_pc !== 32'h00400300) begin
      n_err++; $display("FAIL mid_drain got=%h/%h exp=00000004/00400300", imem_addr, fetch_pc);
    end
    reset = 1'b1; imem_ack = 1'b1;
    tick();
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    n_cmp++; if (fetch_pc !== 32'h00400020 || imem_addr !== 32'h00400020 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_reset got=%h/%h/%b exp=00400020/00400020/0", fetch_pc, imem_addr, inst_valid);
    end
  endtask

  task automatic test_stall;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
`ifdef IFETCH_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 32'd10) begin n_err++; $display("FAIL stall_cnt got=%0d exp=10", stall_cycles); end
`else
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL stall_cnt got=%0d exp=0", stall_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_drain();
    test_redirect_ack_pop();
    test_wrap_and_reset();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
